alu_result_arbiter: RTL
=======================

ALU_RESULT_ARBITER -- requirements
Module: alu_result_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have DATA_SIZE, 16, adder/multiplier result width.
REQ-002 SHALL have ID_SIZE, 8, transaction ID width.
REQ-003 SHALL have OPERATION_SIZE, 2, operation code width (01 ADD, 10 MUL).
REQ-004 SHALL have FIFO_OUT_WIDTH, DATA_SIZE+ID_SIZE+OPERATION_SIZE, FIFO_OUT word width; word = {result, id, op}, op in LSBs.

Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, in, 1, single clock; rst_n, in, 1, reset, asynchronous and active-low.
REQ-006 SHALL have a_res_valid, in, 1, adder result valid; a_result, in, DATA_SIZE; a_id, in, ID_SIZE; a_res_ready, out, 1, adder slot empty.
REQ-007 SHALL have m_res_valid, in, 1; m_result, in, DATA_SIZE; m_id, in, ID_SIZE; m_res_ready, out, 1; all with the same meanings for the multiplier.
REQ-008 SHALL have full_out, in, 1, FIFO_OUT full; w_en_out, out, 1, FIFO_OUT write strobe; fifo_out_data, out, FIFO_OUT_WIDTH, write word.
REQ-009 SHALL have op_done, out, 1, one-cycle pulse per completed write; wr_cnt, out, 8, count of completed writes.

Function
REQ-010 SHALL hold one slot per source: {result, id, full}; the slot captures on the edge where valid & ready = 1.
REQ-011 SHALL drive x_res_ready = !slot_full, registered; ready returns high the cycle after its slot is cleared.
REQ-012 SHALL implement FSM IDLE/WRITE: IDLE -> WRITE when any slot is full, latching the grant and the output word; WRITE -> IDLE on the cycle w_en_out = 1.
REQ-013 SHALL drive w_en_out = (state == WRITE) & !full_out, combinationally; while full_out = 1 in WRITE, stay in WRITE with fifo_out_data stable.
REQ-014 SHALL clear the granted slot, pulse op_done and increment wr_cnt on the same edge where w_en_out = 1; wr_cnt wraps 255 -> 0.
REQ-015 SHALL write the ADD op code 2'b01 for adder words and the MUL op code 2'b10 for multiplier words.
REQ-016 SHALL give a latency of 2 cycles, uncontended with full_out = 0, from the accept edge to the w_en_out cycle; sustained throughput is one write per 2 cycles.
REQ-017 SHALL let the non-granted slot stay full and keep its data while the other source is written; it is granted on the next IDLE.
REQ-018 SHALL, when a slot captures on the same edge as IDLE -> WRITE, exclude it from that grant and arbitrate it next.
REQ-019 SHALL, when both slots are full in IDLE, arbitrate per the Configuration section.

Reset
REQ-020 SHALL on rst_n low immediately set: state IDLE; slots empty; a_res_ready = m_res_ready = 1 from the first post-reset edge; w_en_out = 0, fifo_out_data = 0, op_done = 0, wr_cnt = 0; last_grant = MUL.
REQ-021 SHALL, on reset during WRITE, drop the pending word without a write.

Configuration
REQ-022 SHALL with ALU_ARB_RR_EN defined use round-robin: grant the source not recorded in last_grant; last_grant updates on each write.
REQ-023 SHALL without ALU_ARB_RR_EN use fixed priority, ADD over MUL, with no last_grant register.

Structure
REQ-024 SHALL place DATA_SIZE, ID_SIZE, OPERATION_SIZE, op codes and FSM state encodings in the shared package alu_pkg.
REQ-025 SHALL implement each slot as sub-module alu_res_slot, instantiated twice; all flops use the codebase's d_ff_async_en.

Verification
REQ-026 SHALL check: ADD a_result = 16'h1234, a_id = 8'h05, full_out = 0 -> w_en_out = 1 two cycles after accept, word {16'h1234, 8'h05, 2'b01}, wr_cnt = 1.
REQ-027 SHALL check: ADD and MUL accepted on the same edge, RR build -> ADD written first, then MUL 2 cycles later; a second simultaneous pair -> MUL first.
REQ-028 SHALL check: the same simultaneous pair on a non-RR build -> ADD first on both occasions.
REQ-029 SHALL check: full_out = 1 for 5 cycles during WRITE -> w_en_out = 0 and data stable throughout; one write occurs in the cycle full_out falls.
REQ-030 SHALL check: 256 writes -> wr_cnt wraps to 0, with exactly 256 op_done pulses.
REQ-031 SHALL check: rst_n low in WRITE -> no write, all outputs at reset values, both readies high after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, op codes and FSM encoding for the ALU result arbiter
package alu_pkg;
  localparam int DATA_SIZE = 16;
  localparam int ID_SIZE = 8;
  localparam int OPERATION_SIZE = 2;
  localparam logic [OPERATION_SIZE-1:0] OP_ADD = 2'b01;
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = 2'b10;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
endpackage

// File: rtl/alu_res_slot.sv
// alu_res_slot: one-entry holding slot for a single ALU source result
module alu_res_slot #(
  parameter int DATA_SIZE = alu_pkg::DATA_SIZE,
  parameter int ID_SIZE = alu_pkg::ID_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [DATA_SIZE-1:0] result,
  input  logic [ID_SIZE-1:0]   id,
  input  logic                 clr,
  output logic                 ready,
  output logic                 full,
  output logic [DATA_SIZE-1:0] res_q,
  output logic [ID_SIZE-1:0]   id_q
);
  logic cap, full_d;
  logic [DATA_SIZE+ID_SIZE-1:0] data_q;
  assign cap = valid & ready;
  assign full_d = cap | (full & !clr);
  assign {res_q, id_q} = data_q;
  d_ff_async_en #(.W(1)) u_full (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(full_d), .q(full)
  );
  // ready mirrors the next full state so it is already registered when the slot empties
  d_ff_async_en #(.W(1), .RST_VAL(1'b1)) u_ready (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(!full_d), .q(ready)
  );
  d_ff_async_en #(.W(DATA_SIZE+ID_SIZE)) u_data (
    .clk(clk), .rst_n(rst_n), .en(cap), .d({result, id}), .q(data_q)
  );
endmodule

// File: rtl/d_ff_async_en.sv
// d_ff_async_en: enabled register with asynchronous active-low reset
module d_ff_async_en #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/alu_result_arbiter.sv
// alu_result_arbiter: merges adder and multiplier results into FIFO_OUT.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is ADD-over-MUL priority.
module alu_result_arbiter #(
  parameter int DATA_SIZE = alu_pkg::DATA_SIZE,
  parameter int ID_SIZE = alu_pkg::ID_SIZE,
  parameter int OPERATION_SIZE = alu_pkg::OPERATION_SIZE,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_res_valid,
  input  logic [DATA_SIZE-1:0]      a_result,
  input  logic [ID_SIZE-1:0]        a_id,
  output logic                      a_res_ready,
  input  logic                      m_res_valid,
  input  logic [DATA_SIZE-1:0]      m_result,
  input  logic [ID_SIZE-1:0]        m_id,
  output logic                      m_res_ready,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic                      op_done,
  output logic [7:0]                wr_cnt
);
  import alu_pkg::*;
  logic a_full, m_full, a_clr, m_clr, start, pick_mul, grant_mul, st_q;
  logic [DATA_SIZE-1:0] a_res_q, m_res_q;
  logic [ID_SIZE-1:0] a_id_q, m_id_q;
  logic [FIFO_OUT_WIDTH-1:0] word_d;
  state_t state, state_d;
  alu_res_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_a_slot (
    .clk(clk), .rst_n(rst_n), .valid(a_res_valid), .result(a_result), .id(a_id),
    .clr(a_clr), .ready(a_res_ready), .full(a_full), .res_q(a_res_q), .id_q(a_id_q)
  );
  alu_res_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_m_slot (
    .clk(clk), .rst_n(rst_n), .valid(m_res_valid), .result(m_result), .id(m_id),
    .clr(m_clr), .ready(m_res_ready), .full(m_full), .res_q(m_res_q), .id_q(m_id_q)
  );
`ifdef ALU_ARB_RR_EN
  logic last_mul;
  d_ff_async_en #(.W(1), .RST_VAL(1'b1)) u_last (
    .clk(clk), .rst_n(rst_n), .en(w_en_out), .d(grant_mul), .q(last_mul)
  );
  assign pick_mul = m_full & (!a_full | !last_mul);
`else
  assign pick_mul = !a_full;
`endif
  // slot flags are registered, so a slot capturing on this edge cannot join this grant
  assign state = state_t'(st_q);
  assign start = (state == IDLE) & (a_full | m_full);
  assign w_en_out = (state == WRITE) & !full_out;
  assign state_d = start ? WRITE : (w_en_out ? IDLE : state);
  assign word_d = pick_mul ? {m_res_q, m_id_q, OPERATION_SIZE'(OP_MUL)}
                           : {a_res_q, a_id_q, OPERATION_SIZE'(OP_ADD)};
  assign a_clr = w_en_out & !grant_mul;
  assign m_clr = w_en_out & grant_mul;
  d_ff_async_en #(.W(1)) u_state (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d), .q(st_q)
  );
  d_ff_async_en #(.W(1)) u_grant (
    .clk(clk), .rst_n(rst_n), .en(start), .d(pick_mul), .q(grant_mul)
  );
  d_ff_async_en #(.W(FIFO_OUT_WIDTH)) u_word (
    .clk(clk), .rst_n(rst_n), .en(start), .d(word_d), .q(fifo_out_data)
  );
  d_ff_async_en #(.W(1)) u_done (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(w_en_out), .q(op_done)
  );
  d_ff_async_en #(.W(8)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(w_en_out), .d(wr_cnt + 8'd1), .q(wr_cnt)
  );
endmodule
